// File: rtl/quire_accumulator.sv
// quire_accumulator: registered signed quire accumulation with per-beat wrap or saturation.
// Beats are summed over a valid/ready handshake, and the result is held until out_ready takes it.
module quire_accumulator #(
   parameter int QW  = 64,
   parameter int CW  = 16,
   parameter int SAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [QW-1:0] in_data,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [QW-1:0] out_data,
   output logic [CW-1:0] out_count,
   output logic          out_ovf
);
   typedef enum logic {ACC, HOLD} state_t;
   state_t        state;
   logic [QW-1:0] acc, sum, nxt;
   logic [CW-1:0] count;
   logic          ovf, over;
   assign in_ready  = state == ACC && !flush && !rst;
   assign sum       = acc + in_data;
   assign over      = acc[QW-1] == in_data[QW-1] && sum[QW-1] != acc[QW-1];
   // the rail follows the operand sign, so both operands agree on it when overflow occurs
   assign nxt       = over && SAT != 0 ? {in_data[QW-1], {(QW-1){~in_data[QW-1]}}} : sum;
   assign out_data  = acc;
   assign out_count = count;
   assign out_ovf   = ovf;
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACC;
         acc       <= '0;
         count     <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else if (state == ACC) begin
         if (flush) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
         end else if (in_valid) begin
            acc   <= nxt;
            count <= count + CW'(count != '1);
            ovf   <= ovf | over;
            if (in_last) begin
               state     <= HOLD;
               out_valid <= 1'b1;
            end
         end
      end else if (out_ready) begin
         state     <= ACC;
         acc       <= '0;
         count     <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_quire_accumulator.sv
// tb_quire_accumulator: directed checks on a saturating (CW=16) and a wrapping (CW=2) 16-bit quire.
module tb_quire_accumulator;
   logic        clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic [15:0] in_data = '0;
   logic        rdy0, rdy1, ov0, ov1, of0, of1;
   logic [15:0] d0, d1;
   logic [15:0] c0;
   logic [1:0]  c1;
   int          n_checks = 0, n_fail = 0;

   quire_accumulator #(.QW(16), .CW(16), .SAT(1)) dut0 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
      .in_last(in_last), .out_valid(ov0), .out_ready(out_ready), .out_data(d0), .out_count(c0), .out_ovf(of0));
   quire_accumulator #(.QW(16), .CW(2), .SAT(0)) dut1 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
      .in_last(in_last), .out_valid(ov1), .out_ready(out_ready), .out_data(d1), .out_count(c1), .out_ovf(of1));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [15:0] d, input logic l);
      in_valid = 1'b1; in_data = d; in_last = l;
      step();
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_checks++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_rst: got %b want 0", rdy0); end
      step(); step();
      rst = 1'b0;
      #1;
      n_checks++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ov0); end
      n_checks++; if (d0 !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0000", d0); end
      n_checks++; if (c0 !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", c0); end
      n_checks++; if (of0 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", of0); end
      n_checks++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", rdy0); end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      beat(16'd5, 1'b0);
      beat(-16'sd3, 1'b0);
      beat(16'd100, 1'b1);
      n_checks++; if (ov0 !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", ov0); end
      n_checks++; if (d0 !== 16'd102) begin n_fail++; $display("FAIL basic_data: got %0d want 102", d0); end
      n_checks++; if (c0 !== 16'd3) begin n_fail++; $display("FAIL basic_count: got %0d want 3", c0); end
      n_checks++; if (of0 !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b want 0", of0); end
      n_checks++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL basic_ready_hold: got %b want 0", rdy0); end
      step();
      n_checks++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL basic_valid_clr: got %b want 0", ov0); end
      n_checks++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL basic_ready_back: got %b want 1", rdy0); end
      n_checks++; if (d0 !== 16'd0) begin n_fail++; $display("FAIL basic_data_clr: got %0d want 0", d0); end
   endtask

   task automatic test_overflow_hold();
      out_ready = 1'b0;
      beat(16'h7000, 1'b0);
      n_checks++; if (d0 !== 16'h7000) begin n_fail++; $display("FAIL ovf_first: got %h want 7000", d0); end
      beat(16'h2000, 1'b0);
      n_checks++; if (d0 !== 16'h7FFF) begin n_fail++; $display("FAIL ovf_sat: got %h want 7fff", d0); end
      n_checks++; if (d1 !== 16'h9000) begin n_fail++; $display("FAIL ovf_wrap: got %h want 9000", d1); end
      n_checks++; if (of0 !== 1'b1 || of1 !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b%b want 11", of0, of1); end
      beat(16'hFFFF, 1'b1);
      n_checks++; if (d0 !== 16'h7FFE) begin n_fail++; $display("FAIL ovf_sat_result: got %h want 7ffe", d0); end
      n_checks++; if (d1 !== 16'h8FFF) begin n_fail++; $display("FAIL ovf_wrap_result: got %h want 8fff", d1); end
      n_checks++; if (of0 !== 1'b1 || of1 !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b%b want 11", of0, of1); end
      n_checks++; if (ov0 !== 1'b1 || ov1 !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %b%b want 11", ov0, ov1); end
      in_valid = 1'b1; in_data = 16'd55; flush = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL hold_ready[%0d]: got %b want 0", i, rdy0); end
         n_checks++; if (ov0 !== 1'b1 || d0 !== 16'h7FFE || c0 !== 16'd3 || of0 !== 1'b1)
            begin n_fail++; $display("FAIL hold_stable[%0d]: got v=%b d=%h c=%0d o=%b want v=1 d=7ffe c=3 o=1", i, ov0, d0, c0, of0); end
         step();
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      step();
      n_checks++; if (ov0 !== 1'b0 || d0 !== 16'h0 || c0 !== 16'd0 || of0 !== 1'b0)
         begin n_fail++; $display("FAIL hold_clear: got v=%b d=%h c=%0d o=%b want v=0 d=0 c=0 o=0", ov0, d0, c0, of0); end
      n_checks++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL hold_ready_back: got %b want 1", rdy0); end
   endtask

   task automatic test_flush();
      out_ready = 1'b1;
      beat(16'd10, 1'b0);
      beat(16'd20, 1'b0);
      flush = 1'b1;
      #1;
      n_checks++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", rdy0); end
      beat(16'd30, 1'b0);
      flush = 1'b0;
      n_checks++; if (d0 !== 16'd0 || c0 !== 16'd0) begin n_fail++; $display("FAIL flush_clear: got d=%0d c=%0d want 0 0", d0, c0); end
      beat(16'd7, 1'b1);
      n_checks++; if (ov0 !== 1'b1 || d0 !== 16'd7 || c0 !== 16'd1 || of0 !== 1'b0)
         begin n_fail++; $display("FAIL flush_result: got v=%b d=%0d c=%0d o=%b want v=1 d=7 c=1 o=0", ov0, d0, c0, of0); end
      step();
   endtask

   task automatic test_rst_mid();
      beat(16'd8, 1'b0);
      beat(16'd9, 1'b0);
      n_checks++; if (d0 !== 16'd17) begin n_fail++; $display("FAIL rstmid_pre: got %0d want 17", d0); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++; if (d0 !== 16'd0 || c0 !== 16'd0 || ov0 !== 1'b0)
         begin n_fail++; $display("FAIL rstmid_clear: got d=%0d c=%0d v=%b want 0 0 0", d0, c0, ov0); end
      beat(16'd4, 1'b1);
      n_checks++; if (ov0 !== 1'b1 || d0 !== 16'd4 || c0 !== 16'd1)
         begin n_fail++; $display("FAIL rstmid_result: got v=%b d=%0d c=%0d want v=1 d=4 c=1", ov0, d0, c0); end
      step();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 16'd1; in_last = 1'b1;
      step();
      n_checks++; if (ov0 !== 1'b1 || d0 !== 16'd1 || c0 !== 16'd1)
         begin n_fail++; $display("FAIL b2b_first: got v=%b d=%0d c=%0d want v=1 d=1 c=1", ov0, d0, c0); end
      n_checks++; if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_ready: got %b want 0", rdy0); end
      in_data = 16'd2;
      step();
      n_checks++; if (ov0 !== 1'b0 || rdy0 !== 1'b1) begin n_fail++; $display("FAIL b2b_rearm: got v=%b r=%b want v=0 r=1", ov0, rdy0); end
      step();
      in_valid = 1'b0; in_last = 1'b0;
      n_checks++; if (ov0 !== 1'b1 || d0 !== 16'd2 || c0 !== 16'd1)
         begin n_fail++; $display("FAIL b2b_second: got v=%b d=%0d c=%0d want v=1 d=2 c=1", ov0, d0, c0); end
      step();
   endtask

   task automatic test_count_sat();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) beat(16'd1, 1'b0);
      beat(16'd1, 1'b1);
      n_checks++; if (c0 !== 16'd5) begin n_fail++; $display("FAIL count_wide: got %0d want 5", c0); end
      n_checks++; if (c1 !== 2'd3) begin n_fail++; $display("FAIL count_sat: got %0d want 3", c1); end
      n_checks++; if (d1 !== 16'd5) begin n_fail++; $display("FAIL count_data: got %0d want 5", d1); end
      out_ready = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow_hold();
      test_flush();
      test_rst_mid();
      test_back_to_back();
      test_count_sat();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
